rv_iopmp_entry_encoder: RTL and testbench
=========================================

# rv_iopmp_entry_encoder

Converts a software-level region request (base, byte length, permissions, target entry index) into IOPMP entry programming writes. It chooses the tightest address-matching mode (NA4, NAPOT, or TOR) and drives one or two handshaked writes into the entry register table. It sits between the configuration front-end and the entry table, and produces exactly the `addr`/`addrh`/mode/permission encoding that the matching logic decodes.

## Interface
Parameters:
- `LEN`, 32: width of each entry address register half (`addr`, `addrh`).
- `ADDR_WIDTH`, 64: width of the request base and length fields.
- `NUM_ENTRY`, 16: number of entries in the table. Index width is `$clog2(NUM_ENTRY)`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous assertion, active-low.
- `req_valid_i`  in  1  region request valid.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_base_i`  in  ADDR_WIDTH  region base byte address.
- `req_size_i`  in  ADDR_WIDTH  region length in bytes.
- `req_perm_i`  in  3  {X,W,R} permissions.
- `req_idx_i`  in  $clog2(NUM_ENTRY)  first target entry index.
- `wr_valid_o`  out  1  entry write valid.
- `wr_ready_i`  in  1  entry table accepts the write.
- `wr_idx_o`  out  $clog2(NUM_ENTRY)  entry index being written.
- `wr_addr_o`, `wr_addrh_o`  out  LEN each  entry address field, low and high halves. The field holds byte address bits 65:2.
- `wr_mode_o`  out  `rv_iopmp_pkg::mode_t`  entry mode.
- `wr_perm_o`  out  3  entry permissions.
- `rsp_valid_o`  out  1  one-cycle completion pulse.
- `rsp_status_o`  out  `rv_iopmp_pkg::enc_status_t`  completion status.
- `rsp_mode_o`  out  `rv_iopmp_pkg::mode_t`  mode that was chosen.

## Operation
- States: IDLE → CALC → (WR_PREV →) WR_ENTRY → RESP → IDLE. On error, CALC → RESP.
- IDLE:
  - `req_ready_o` is 1 in IDLE only.
  - On acceptance, register base, size, perm and idx.
- CALC classifies the request. The first matching rule applies:
  - base[1:0] ≠ 0 or size[1:0] ≠ 0 → ENC_ERR_ALIGN.
  - size == 0, or base+size > 2^ADDR_WIDTH → ENC_ERR_RANGE. The sum is computed in ADDR_WIDTH+1 bits; a sum exactly equal to 2^ADDR_WIDTH is legal.
  - size == 4 → NA4, single write, field = base>>2.
  - size is a power of two, size ≥ 8, and base is size-aligned → NAPOT, single write, field = (base>>2) | (size/8 − 1).
  - Otherwise TOR. If idx == NUM_ENTRY−1 → ENC_ERR_IDX.
- TOR write sequence:
  - WR_PREV writes idx with field = base>>2, mode OFF, perm 0.
  - WR_ENTRY then writes idx+1 with field = (base+size)>>2, mode TOR, perm = req perm.
- Single-write modes go CALC → WR_ENTRY at idx.
- The 64-bit field is zero-extended into {`wr_addrh_o`, `wr_addr_o`}.
- RESP:
  - `rsp_valid_o` is 1 for exactly one cycle, with `rsp_status_o` and `rsp_mode_o` valid.
  - `rsp_mode_o` is OFF on error.
  - An error produces no writes.

## Timing
- Reset values: `req_ready_o` = 0 while in reset and 1 in the first IDLE cycle after reset. Every other output is 0. The state is IDLE.
- Latency, single write with `wr_ready_i` held high: accept at cycle 0, CALC at 1, write valid at 2, `rsp_valid_o` at 3.
- Latency, TOR: `rsp_valid_o` at cycle 4 at the earliest.
- Latency, error: `rsp_valid_o` at cycle 2.
- `wr_valid_o` is asserted only in WR_PREV and WR_ENTRY.
- While `wr_valid_o` is high and `wr_ready_i` is low, all `wr_*` outputs hold stable.
- The state advances on the cycle in which `wr_valid_o` and `wr_ready_i` are both high.
- There is no combinational path from `wr_ready_i` or `req_valid_i` to any output except through registered state.
- Inputs on the `req_*` ports are ignored outside the acceptance cycle.
- Reset asserted mid-operation: all outputs clear asynchronously, any pending write is dropped, and no response is issued.

## Configuration
- `RV_IOPMP_ENC_NAPOT_EN` defined: NA4/NAPOT classification is active, as described above.
- `RV_IOPMP_ENC_NAPOT_EN` undefined:
  - Every legal request is encoded as TOR with two writes.
  - The classification logic is removed.
  - `rsp_mode_o` is only ever TOR or OFF.

## Structure
- `rv_iopmp_pkg` provides the existing `mode_t` (OFF = 0, TOR = 1, NA4 = 2, NAPOT = 3).
- Add to `rv_iopmp_pkg`: the 2-bit `enc_status_t` (ENC_OK = 0, ENC_ERR_ALIGN = 1, ENC_ERR_RANGE = 2, ENC_ERR_IDX = 3).
- The FSM state enum stays local to the module.
- Sub-module `rv_iopmp_region_classifier` (combinational):
  - Inputs: base, size, idx.
  - Outputs: status, mode, primary field, TOR end field.
  - Its output is registered in CALC.

## Test plan
- base 0x8000_0000, size 4, idx 5 → one write: idx 5, NA4, field 0x0000_0000_2000_0000, `rsp_status_o` = ENC_OK at cycle 3.
- base 0x8000_0000, size 0x1000, perm 3'b011, idx 0 → one write: NAPOT, field 0x2000_01FF, perm 011. With the macro undefined, the same request yields TOR writes of 0x2000_0000 and 0x2000_0400.
- base 0x1000, size 0x3000, idx 2 → idx 2 OFF field 0x400, then idx 3 TOR field 0x1000.
- base 0x1002, size 8 → no write, ENC_ERR_ALIGN at cycle 2.
- base 0xFFFF_FFFF_FFFF_F000, size 0x2000 → ENC_ERR_RANGE.
- base 0x3000, size 0x1800, idx 15 → ENC_ERR_IDX.
- TOR request with `wr_ready_i` low for 5 cycles → `wr_*` outputs stable throughout.
- Then `rst_ni` low during WR_ENTRY → all outputs 0 immediately, and no `rsp_valid_o` after release.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: entry address-matching modes and region encoder completion status.
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ENC_OK        = 2'd0,
        ENC_ERR_ALIGN = 2'd1,
        ENC_ERR_RANGE = 2'd2,
        ENC_ERR_IDX   = 2'd3
    } enc_status_t;

endpackage

// File: rtl/rv_iopmp_region_classifier.sv
// Combinational region classifier: picks the tightest entry mode and the entry address fields.
// NA4/NAPOT selection is present only when RV_IOPMP_ENC_NAPOT_EN is defined; otherwise every legal region is TOR.
module rv_iopmp_region_classifier
    import rv_iopmp_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_ENTRY  = 16,
    localparam int IDX_W     = $clog2(NUM_ENTRY),
    localparam int FIELD_W   = 2 * LEN
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] size,
    input  logic [IDX_W-1:0]      idx,
    output enc_status_t           status,
    output mode_t                 mode,
    output logic [FIELD_W-1:0]    prim_field,
    output logic [FIELD_W-1:0]    end_field
);

    logic [ADDR_WIDTH:0] end_addr;
    logic                align_err;
    logic                range_err;

    // One extra bit so a region ending exactly at the top of the address space stays legal.
    assign end_addr  = {1'b0, base} + {1'b0, size};
    assign align_err = (base[1:0] != 2'b00) || (size[1:0] != 2'b00);
    assign range_err = (size == '0) || (end_addr[ADDR_WIDTH] && (end_addr[ADDR_WIDTH-1:0] != '0));
    assign end_field = FIELD_W'(end_addr >> 2);

`ifdef RV_IOPMP_ENC_NAPOT_EN
    logic [ADDR_WIDTH-1:0] size_mask;
    logic                  is_na4;
    logic                  is_napot;

    assign size_mask = size - ADDR_WIDTH'(1);
    assign is_na4    = (size == ADDR_WIDTH'(4));
    assign is_napot  = (size >= ADDR_WIDTH'(8)) && ((size & size_mask) == '0) && ((base & size_mask) == '0);
`endif

    always_comb begin
        status     = ENC_OK;
        mode       = TOR;
        prim_field = FIELD_W'(base >> 2);
        if (align_err) begin
            status = ENC_ERR_ALIGN;
            mode   = OFF;
        end else if (range_err) begin
            status = ENC_ERR_RANGE;
            mode   = OFF;
        end
`ifdef RV_IOPMP_ENC_NAPOT_EN
        else if (is_na4) begin
            mode = NA4;
        end else if (is_napot) begin
            mode       = NAPOT;
            prim_field = FIELD_W'((base >> 2) | ((size >> 3) - ADDR_WIDTH'(1)));
        end
`endif
        else if (idx == IDX_W'(NUM_ENTRY - 1)) begin
            // TOR needs idx+1, which does not exist for the last entry.
            status = ENC_ERR_IDX;
            mode   = OFF;
        end
    end

endmodule

// File: rtl/rv_iopmp_entry_encoder.sv
// Turns a region request into one (NA4/NAPOT) or two (TOR) handshaked IOPMP entry writes plus a completion pulse.
// Optional RV_IOPMP_ENC_NAPOT_EN enables NA4/NAPOT encoding; without it every legal region is written as TOR.
module rv_iopmp_entry_encoder
    import rv_iopmp_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_ENTRY  = 16,
    localparam int IDX_W     = $clog2(NUM_ENTRY)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_base_i,
    input  logic [ADDR_WIDTH-1:0] req_size_i,
    input  logic [2:0]            req_perm_i,
    input  logic [IDX_W-1:0]      req_idx_i,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [IDX_W-1:0]      wr_idx_o,
    output logic [LEN-1:0]        wr_addr_o,
    output logic [LEN-1:0]        wr_addrh_o,
    output mode_t                 wr_mode_o,
    output logic [2:0]            wr_perm_o,
    output logic                  rsp_valid_o,
    output enc_status_t           rsp_status_o,
    output mode_t                 rsp_mode_o
);

    localparam int FIELD_W = 2 * LEN;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WR_PREV,
        WR_ENTRY,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  ready_q;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] base_q, size_q;
    logic [2:0]            perm_q;
    logic [IDX_W-1:0]      idx_q;
    enc_status_t           status_q, cls_status;
    mode_t                 mode_q, cls_mode;
    logic [FIELD_W-1:0]    prim_q, cls_prim;
    logic [FIELD_W-1:0]    end_q, cls_end;
    logic [FIELD_W-1:0]    wr_field;

    assign req_ready_o = ready_q;
    assign accept      = req_valid_i && ready_q;

    rv_iopmp_region_classifier #(
        .LEN        (LEN),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ENTRY  (NUM_ENTRY)
    ) u_classifier (
        .base       (base_q),
        .size       (size_q),
        .idx        (idx_q),
        .status     (cls_status),
        .mode       (cls_mode),
        .prim_field (cls_prim),
        .end_field  (cls_end)
    );

    // Ready is a flop so it reads 0 throughout reset and rises on the first clock after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            base_q   <= '0;
            size_q   <= '0;
            perm_q   <= '0;
            idx_q    <= '0;
            status_q <= ENC_OK;
            mode_q   <= OFF;
            prim_q   <= '0;
            end_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                base_q <= req_base_i;
                size_q <= req_size_i;
                perm_q <= req_perm_i;
                idx_q  <= req_idx_i;
            end
            if (state_q == CALC) begin
                status_q <= cls_status;
                mode_q   <= cls_mode;
                prim_q   <= cls_prim;
                end_q    <= cls_end;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = CALC;
            CALC: begin
                if (cls_status != ENC_OK) state_d = RESP;
                else if (cls_mode == TOR) state_d = WR_PREV;
                else                      state_d = WR_ENTRY;
            end
            WR_PREV:  if (wr_ready_i) state_d = WR_ENTRY;
            WR_ENTRY: if (wr_ready_i) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so they hold steady while a write is stalled.
    always_comb begin
        wr_valid_o   = 1'b0;
        wr_idx_o     = '0;
        wr_field     = '0;
        wr_mode_o    = OFF;
        wr_perm_o    = 3'b000;
        rsp_valid_o  = 1'b0;
        rsp_status_o = ENC_OK;
        rsp_mode_o   = OFF;
        case (state_q)
            WR_PREV: begin
                wr_valid_o = 1'b1;
                wr_idx_o   = idx_q;
                wr_field   = prim_q;
            end
            WR_ENTRY: begin
                wr_valid_o = 1'b1;
                wr_mode_o  = mode_q;
                wr_perm_o  = perm_q;
                if (mode_q == TOR) begin
                    wr_idx_o = idx_q + IDX_W'(1);
                    wr_field = end_q;
                end else begin
                    wr_idx_o = idx_q;
                    wr_field = prim_q;
                end
            end
            RESP: begin
                rsp_valid_o  = 1'b1;
                rsp_status_o = status_q;
                rsp_mode_o   = (status_q == ENC_OK) ? mode_q : OFF;
            end
            default: ;
        endcase
    end

    assign {wr_addrh_o, wr_addr_o} = wr_field;

endmodule

// File: tb/tb_rv_iopmp_entry_encoder.sv
// Self-checking bench for rv_iopmp_entry_encoder: behavioural region model, scoreboard queues, random traffic.
// Follows RV_IOPMP_ENC_NAPOT_EN the same way the design does.
module tb_rv_iopmp_entry_encoder;
    import rv_iopmp_pkg::*;

    localparam int LEN = 32;
    localparam int AW  = 64;
    localparam int NE  = 16;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_base_i = '0;
    logic [AW-1:0] req_size_i = '0;
    logic [2:0]    req_perm_i = '0;
    logic [IW-1:0] req_idx_i = '0;
    logic          wr_valid_o;
    logic          wr_ready_i = 1'b0;
    logic [IW-1:0] wr_idx_o;
    logic [LEN-1:0] wr_addr_o, wr_addrh_o;
    mode_t         wr_mode_o;
    logic [2:0]    wr_perm_o;
    logic          rsp_valid_o;
    enc_status_t   rsp_status_o;
    mode_t         rsp_mode_o;

    always #5 clk = ~clk;

    rv_iopmp_entry_encoder #(.LEN(LEN), .ADDR_WIDTH(AW), .NUM_ENTRY(NE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_base_i   (req_base_i),
        .req_size_i   (req_size_i),
        .req_perm_i   (req_perm_i),
        .req_idx_i    (req_idx_i),
        .wr_valid_o   (wr_valid_o),
        .wr_ready_i   (wr_ready_i),
        .wr_idx_o     (wr_idx_o),
        .wr_addr_o    (wr_addr_o),
        .wr_addrh_o   (wr_addrh_o),
        .wr_mode_o    (wr_mode_o),
        .wr_perm_o    (wr_perm_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_status_o (rsp_status_o),
        .rsp_mode_o   (rsp_mode_o)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [63:0]   field;
        mode_t         mode;
        logic [2:0]    perm;
    } wr_t;

    typedef struct {
        enc_status_t status;
        mode_t       mode;
        int          cyc0;
        int          lat;
        bit          exact;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cycle = 0;
    int   ready_mode = 0;
    int   rsp_count = 0;

    bit            prev_stall = 1'b0;
    logic [IW-1:0] prev_idx;
    logic [63:0]   prev_field;
    logic [1:0]    prev_mode;
    logic [2:0]    prev_perm;
    wr_t           head;
    rsp_t          rhead;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Region rules stated directly: divisibility, 65-bit end address, power-of-two size.
    function automatic void modelRequest(input logic [63:0] base, input logic [63:0] size,
                                         input logic [IW-1:0] idx, input logic [2:0] perm,
                                         output enc_status_t st, output mode_t md,
                                         output int nwr, output wr_t w0, output wr_t w1);
        logic [64:0] top_addr;
        top_addr = {1'b0, base} + {1'b0, size};
        nwr = 0;
        w0.idx = '0; w0.field = '0; w0.mode = OFF; w0.perm = '0;
        w1 = w0;
        st = ENC_OK;
        md = OFF;
        if ((base % 4) != 0 || (size % 4) != 0) begin
            st = ENC_ERR_ALIGN;
        end else if (size == 0 || top_addr > (65'd1 << 64)) begin
            st = ENC_ERR_RANGE;
        end
`ifdef RV_IOPMP_ENC_NAPOT_EN
        else if (size == 64'd4) begin
            md = NA4; nwr = 1;
            w0.idx = idx; w0.field = base / 4; w0.mode = NA4; w0.perm = perm;
        end else if ($countones(size) == 1 && size >= 64'd8 && (base % size) == 0) begin
            md = NAPOT; nwr = 1;
            w0.idx = idx; w0.field = base / 4 + size / 8 - 64'd1; w0.mode = NAPOT; w0.perm = perm;
        end
`endif
        else if (idx == IW'(NE - 1)) begin
            st = ENC_ERR_IDX;
        end else begin
            md = TOR; nwr = 2;
            w0.idx = idx; w0.field = base / 4; w0.mode = OFF; w0.perm = 3'b000;
            w1.idx = idx + 4'd1; w1.field = 64'(top_addr / 4); w1.mode = TOR; w1.perm = perm;
        end
    endfunction

    task automatic pinModel(input string name, input logic [63:0] base, input logic [63:0] size,
                            input logic [IW-1:0] idx, input logic [2:0] perm,
                            input enc_status_t exp_st, input int exp_nwr,
                            input logic [63:0] exp_f0, input logic [63:0] exp_f1);
        enc_status_t st;
        mode_t md;
        int nwr;
        wr_t w0, w1;
        modelRequest(base, size, idx, perm, st, md, nwr, w0, w1);
        checkOutput({name, "_status"}, 64'(st), 64'(exp_st));
        checkOutput({name, "_nwr"}, 64'(nwr), 64'(exp_nwr));
        if (nwr >= 1) checkOutput({name, "_field0"}, w0.field, exp_f0);
        if (nwr == 2) checkOutput({name, "_field1"}, w1.field, exp_f1);
    endtask

    task automatic applyStimulus(input logic [63:0] base, input logic [63:0] size,
                                 input logic [2:0] perm, input logic [IW-1:0] idx, input bit exact);
        enc_status_t st;
        mode_t md;
        int nwr;
        int guard;
        wr_t w0, w1;
        rsp_t r;
        modelRequest(base, size, idx, perm, st, md, nwr, w0, w1);
        guard = 0;
        @(negedge clk);
        while (!req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) begin
            checkOutput("req_ready_timeout", 64'(req_ready_o), 64'd1);
            return;
        end
        req_base_i  = base;
        req_size_i  = size;
        req_perm_i  = perm;
        req_idx_i   = idx;
        req_valid_i = 1'b1;
        if (nwr >= 1) wq.push_back(w0);
        if (nwr == 2) wq.push_back(w1);
        r.status = st;
        r.mode   = md;
        r.cyc0   = cycle;
        r.lat    = (nwr == 0) ? 2 : ((nwr == 1) ? 3 : 4);
        r.exact  = exact;
        rq.push_back(r);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_base_i  = {$urandom, $urandom};
        req_size_i  = {$urandom, $urandom};
        req_perm_i  = 3'($urandom_range(0, 7));
        req_idx_i   = 4'($urandom_range(0, 15));
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((wq.size() != 0 || rq.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) checkOutput("drain_timeout", 64'(rq.size()), 64'd0);
        wq.delete();
        rq.delete();
        @(negedge clk);
        #1;
    endtask

    // Single compare process: drives wr_ready_i, checks writes and responses against the scoreboard.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            case (ready_mode)
                1:       wr_ready_i = ($urandom_range(0, 3) != 0);
                2:       wr_ready_i = 1'b0;
                default: wr_ready_i = 1'b1;
            endcase
            if (prev_stall) begin
                checkOutput("stall_idx", 64'(wr_idx_o), 64'(prev_idx));
                checkOutput("stall_field", {wr_addrh_o, wr_addr_o}, prev_field);
                checkOutput("stall_mode", 64'(wr_mode_o), 64'(prev_mode));
                checkOutput("stall_perm", 64'(wr_perm_o), 64'(prev_perm));
            end
            if (wr_valid_o) begin
                if (wq.size() == 0) begin
                    checkOutput("wr_unexpected", 64'(wr_valid_o), 64'd0);
                end else begin
                    head = wq[0];
                    checkOutput("wr_idx", 64'(wr_idx_o), 64'(head.idx));
                    checkOutput("wr_field", {wr_addrh_o, wr_addr_o}, head.field);
                    checkOutput("wr_mode", 64'(wr_mode_o), 64'(head.mode));
                    checkOutput("wr_perm", 64'(wr_perm_o), 64'(head.perm));
                    if (wr_ready_i) begin
                        void'(wq.pop_front());
                        if (ready_mode == 3) ready_mode = 2;
                    end
                end
            end
            prev_stall = wr_valid_o && !wr_ready_i;
            prev_idx   = wr_idx_o;
            prev_field = {wr_addrh_o, wr_addr_o};
            prev_mode  = wr_mode_o;
            prev_perm  = wr_perm_o;
            if (rsp_valid_o) begin
                rsp_count++;
                if (rq.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
                end else begin
                    rhead = rq.pop_front();
                    checkOutput("rsp_status", 64'(rsp_status_o), 64'(rhead.status));
                    checkOutput("rsp_mode", 64'(rsp_mode_o), 64'(rhead.mode));
                    checkOutput("rsp_writes_done", 64'(wq.size()), 64'd0);
                    if (rhead.exact) checkOutput("rsp_latency", 64'(cycle - rhead.cyc0), 64'(rhead.lat));
                end
            end
        end
    end

    initial begin
        logic [63:0] rb, rs;
        int guard;
        int cnt_before;
        int k;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("reset_wr_valid", 64'(wr_valid_o), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("reset_wr_field", {wr_addrh_o, wr_addr_o}, 64'd0);
        checkOutput("reset_wr_idx_mode_perm", {55'd0, wr_idx_o, wr_mode_o, wr_perm_o}, 64'd0);
        checkOutput("reset_rsp_fields", {60'd0, rsp_status_o, rsp_mode_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(req_ready_o), 64'd1);

`ifdef RV_IOPMP_ENC_NAPOT_EN
        pinModel("pin_na4", 64'h8000_0000, 64'd4, 4'd5, 3'b001, ENC_OK, 1, 64'h2000_0000, 64'd0);
        pinModel("pin_napot", 64'h8000_0000, 64'h1000, 4'd0, 3'b011, ENC_OK, 1, 64'h2000_01FF, 64'd0);
        pinModel("pin_top", 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd4, 3'b001, ENC_OK, 1, 64'h3FFF_FFFF_FFFF_FDFF, 64'd0);
`else
        pinModel("pin_na4", 64'h8000_0000, 64'd4, 4'd5, 3'b001, ENC_OK, 2, 64'h2000_0000, 64'h2000_0001);
        pinModel("pin_napot", 64'h8000_0000, 64'h1000, 4'd0, 3'b011, ENC_OK, 2, 64'h2000_0000, 64'h2000_0400);
        pinModel("pin_top", 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd4, 3'b001, ENC_OK, 2, 64'h3FFF_FFFF_FFFF_FC00, 64'h4000_0000_0000_0000);
`endif
        pinModel("pin_tor", 64'h1000, 64'h3000, 4'd2, 3'b101, ENC_OK, 2, 64'h400, 64'h1000);
        pinModel("pin_align", 64'h1002, 64'd8, 4'd1, 3'b001, ENC_ERR_ALIGN, 0, 64'd0, 64'd0);
        pinModel("pin_range", 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 4'd1, 3'b001, ENC_ERR_RANGE, 0, 64'd0, 64'd0);
        pinModel("pin_zero", 64'h4000, 64'd0, 4'd1, 3'b001, ENC_ERR_RANGE, 0, 64'd0, 64'd0);
        pinModel("pin_idx", 64'h3000, 64'h1800, 4'd15, 3'b001, ENC_ERR_IDX, 0, 64'd0, 64'd0);

        ready_mode = 0;
        applyStimulus(64'h8000_0000, 64'd4, 3'b001, 4'd5, 1'b1);
        applyStimulus(64'h8000_0000, 64'h1000, 3'b011, 4'd0, 1'b1);
        applyStimulus(64'h1000, 64'h3000, 3'b101, 4'd2, 1'b1);
        applyStimulus(64'h1002, 64'd8, 3'b001, 4'd1, 1'b1);
        applyStimulus(64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001, 4'd1, 1'b1);
        applyStimulus(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b110, 4'd4, 1'b1);
        applyStimulus(64'h3000, 64'h1800, 3'b001, 4'd15, 1'b1);
        applyStimulus(64'h4000, 64'd0, 3'b001, 4'd3, 1'b1);
        waitDrain();

        // Stalled TOR writes: wr_ready_i held low for several cycles.
        ready_mode = 2;
        applyStimulus(64'h1000, 64'h3000, 3'b111, 4'd7, 1'b0);
        guard = 0;
        while (!wr_valid_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stall_write_seen", 64'(wr_valid_o), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        ready_mode = 0;
        waitDrain();

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    k  = $urandom_range(2, 24);
                    rs = 64'd1 << k;
                    rb = {$urandom, $urandom} & ~(rs - 64'd1);
                end
                1: begin
                    rs = 64'd4;
                    rb = {$urandom, $urandom} & ~64'd3;
                end
                2: begin
                    rs = 64'($urandom_range(1, 65535)) << 2;
                    rb = {$urandom, $urandom} & ~64'd3;
                end
                3: begin
                    rb = 64'hFFFF_FFFF_FFFF_0000 | (64'($urandom_range(0, 16383)) << 2);
                    rs = 64'($urandom_range(0, 32768)) << 2;
                end
                4: begin
                    rb = {$urandom, $urandom};
                    rs = 64'($urandom_range(0, 65535));
                end
                default: begin
                    rb = 64'($urandom_range(0, 1023)) << 2;
                    rs = 64'($urandom_range(1, 256)) << 2;
                end
            endcase
            ready_mode = (i < 60) ? 0 : 1;
            applyStimulus(rb, rs, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), i < 60);
            if (i == 59) waitDrain();
        end
        waitDrain();

        // Reset while the second TOR write is stalled: no response may follow.
        ready_mode = 3;
        applyStimulus(64'h1000, 64'h3000, 3'b011, 4'd2, 1'b0);
        guard = 0;
        while (!(wr_valid_o && wr_idx_o == 4'd3) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reset_test_in_wr_entry", 64'(wr_idx_o), 64'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset_wr_valid", 64'(wr_valid_o), 64'd0);
        checkOutput("midreset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("midreset_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("midreset_wr_field", {wr_addrh_o, wr_addr_o}, 64'd0);
        checkOutput("midreset_wr_idx_mode_perm", {55'd0, wr_idx_o, wr_mode_o, wr_perm_o}, 64'd0);
        wq.delete();
        rq.delete();
        ready_mode = 0;
        cnt_before = rsp_count;
        repeat (2) @(negedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rsp_after_reset", 64'(rsp_count - cnt_before), 64'd0);
        checkOutput("ready_after_midreset", 64'(req_ready_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
